trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl -- write-back stage trap / MRET sequencer.
//
// Detects a trap event (enabled interrupt or synchronous exception) or an
// MRET on the valid instruction in WB, then walks a fixed sequence:
//   trap : IDLE -> FLUSH -> WRITE -> REDIRECT -> IDLE
//   mret : IDLE -> FLUSH -> REDIRECT -> IDLE
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i, pc_i,          WB-stage instruction valid / PC / encoding
//   instruction_i
//   mem_addr_i              load/store effective address (mtval for misaligned)
//   e_*_i, is_*_i           synchronous exception flags, decoded SYSTEM ops
//   xint_*_i                interrupt pending lines
//   mstatus_mie_i, mie_i    global and per-source interrupt enables
//   mtvec_i, mepc_i         trap vector and current mepc CSRs
//   kill_wb_o               suppress RF write of the WB instruction
//   stall_o, flush_o        pipeline freeze / IF..MEM invalidate
//   we_exc_o                one-cycle CSR trap write strobe
//   mcause_o, mepc_o,       latched trap cause / PC / value
//   mtval_o
//   mret_o                  one-cycle mstatus restore strobe
//   redirect_o,             one-cycle fetch redirect and its target
//   redirect_pc_o
module trap_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [31:0] mem_addr_i,
    input  logic        e_inst_addr_mis_i,
    input  logic        e_illegal_inst_i,
    input  logic        e_ld_addr_mis_i,
    input  logic        e_st_addr_mis_i,
    input  logic        is_ecall_i,
    input  logic        is_ebreak_i,
    input  logic        is_mret_i,
    input  logic        xint_meip_i,
    input  logic        xint_msip_i,
    input  logic        xint_mtip_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        kill_wb_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        we_exc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic        mret_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WRITE,
        REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcause_q, mepc_q, mtval_q;
    logic        mret_q;

    logic        irq_mei, irq_msi, irq_mti, irq_any;
    logic        sync_any, idle_valid, trap_event, mret_accept;
    logic [31:0] cause_sel, tval_sel;
    logic [31:0] vec_base, trap_target;

    assign irq_mei = mstatus_mie_i & xint_meip_i & mie_i[11];
    assign irq_msi = mstatus_mie_i & xint_msip_i & mie_i[3];
    assign irq_mti = mstatus_mie_i & xint_mtip_i & mie_i[7];
    assign irq_any = irq_mei | irq_msi | irq_mti;

    assign sync_any = e_inst_addr_mis_i | e_illegal_inst_i | is_ebreak_i |
                      is_ecall_i | e_ld_addr_mis_i | e_st_addr_mis_i;

    assign idle_valid  = (state_q == IDLE) & valid_i;
    assign trap_event  = idle_valid & (irq_any | sync_any);
    assign mret_accept = idle_valid & is_mret_i & ~trap_event;

    // Cause / value selection: interrupts first, then synchronous sources.
    always_comb begin
        cause_sel = '0;
        tval_sel  = '0;
        if (irq_mei) begin
            cause_sel = 32'h8000_000B;
        end else if (irq_msi) begin
            cause_sel = 32'h8000_0003;
        end else if (irq_mti) begin
            cause_sel = 32'h8000_0007;
        end else if (e_inst_addr_mis_i) begin
            cause_sel = 32'd0;
            tval_sel  = pc_i;
        end else if (e_illegal_inst_i) begin
            cause_sel = 32'd2;
            tval_sel  = instruction_i;
        end else if (is_ebreak_i) begin
            cause_sel = 32'd3;
            tval_sel  = pc_i;
        end else if (is_ecall_i) begin
            cause_sel = 32'd11;
        end else if (e_ld_addr_mis_i) begin
            cause_sel = 32'd4;
            tval_sel  = mem_addr_i;
        end else if (e_st_addr_mis_i) begin
            cause_sel = 32'd6;
            tval_sel  = mem_addr_i;
        end
    end

    // Vectored mode only applies to interrupts; offset is 4 * cause code.
    assign vec_base = {mtvec_i[31:2], 2'b00};
    always_comb begin
        if (mtvec_i[1:0] == 2'b01 && mcause_q[31])
            trap_target = vec_base + {mcause_q[29:0], 2'b00};
        else
            trap_target = vec_base;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcause_q <= '0;
            mepc_q   <= '0;
            mtval_q  <= '0;
            mret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trap_event) begin
                mcause_q <= cause_sel;
                mtval_q  <= tval_sel;
                mepc_q   <= pc_i;
                mret_q   <= 1'b0;
            end else if (mret_accept) begin
                mret_q <= 1'b1;
            end
        end
    end

    // Every strobe is gated by rst_i so nothing fires while reset is held,
    // even if the state register has not yet returned to IDLE.
    always_comb begin
        state_d       = state_q;
        kill_wb_o     = 1'b0;
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        we_exc_o      = 1'b0;
        mret_o        = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (state_q)
            IDLE: begin
                if (trap_event || mret_accept) begin
                    kill_wb_o = ~rst_i;
                    state_d   = FLUSH;
                end
            end
            FLUSH: begin
                stall_o = ~rst_i;
                flush_o = ~rst_i;
                state_d = mret_q ? REDIRECT : WRITE;
            end
            WRITE: begin
                stall_o  = ~rst_i;
                we_exc_o = ~rst_i;
                state_d  = REDIRECT;
            end
            REDIRECT: begin
                stall_o       = ~rst_i;
                redirect_o    = ~rst_i;
                mret_o        = ~rst_i & mret_q;
                redirect_pc_o = mret_q ? mepc_i : trap_target;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mcause_o = mcause_q;
    assign mepc_o   = mepc_q;
    assign mtval_o  = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, instruction_i, mem_addr_i;
    logic        e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i;
    logic        is_ecall_i, is_ebreak_i, is_mret_i;
    logic        xint_meip_i, xint_msip_i, xint_mtip_i, mstatus_mie_i;
    logic [31:0] mie_i, mtvec_i, mepc_i;
    logic        kill_wb_o, stall_o, flush_o, we_exc_o, mret_o, redirect_o;
    logic [31:0] mcause_o, mepc_o, mtval_o, redirect_pc_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    trap_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .instruction_i(instruction_i), .mem_addr_i(mem_addr_i),
        .e_inst_addr_mis_i(e_inst_addr_mis_i), .e_illegal_inst_i(e_illegal_inst_i),
        .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
        .is_ecall_i(is_ecall_i), .is_ebreak_i(is_ebreak_i), .is_mret_i(is_mret_i),
        .xint_meip_i(xint_meip_i), .xint_msip_i(xint_msip_i), .xint_mtip_i(xint_mtip_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .kill_wb_o(kill_wb_o), .stall_o(stall_o), .flush_o(flush_o), .we_exc_o(we_exc_o),
        .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o), .mret_o(mret_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks follow a settle delay.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 0; pc_i = '0; instruction_i = '0; mem_addr_i = '0;
        e_inst_addr_mis_i = 0; e_illegal_inst_i = 0; e_ld_addr_mis_i = 0; e_st_addr_mis_i = 0;
        is_ecall_i = 0; is_ebreak_i = 0; is_mret_i = 0;
        xint_meip_i = 0; xint_msip_i = 0; xint_mtip_i = 0; mstatus_mie_i = 0; mie_i = '0;
    endtask

    // Called with the event inputs already applied and settled (cycle N).
    task automatic trap_seq(input string tag, input logic [31:0] target);
        chk({tag, "_kill_N"}, {31'b0, kill_wb_o}, 32'd1);
        chk({tag, "_stall_N"}, {31'b0, stall_o}, 32'd0);
        tick(); clear_inputs(); settle();
        chk({tag, "_flush_N1"}, {31'b0, flush_o}, 32'd1);
        chk({tag, "_we_N1"}, {31'b0, we_exc_o}, 32'd0);
        chk({tag, "_kill_N1"}, {31'b0, kill_wb_o}, 32'd0);
        chk({tag, "_stall_N1"}, {31'b0, stall_o}, 32'd1);
        tick(); settle();
        chk({tag, "_we_N2"}, {31'b0, we_exc_o}, 32'd1);
        chk({tag, "_flush_N2"}, {31'b0, flush_o}, 32'd0);
        tick(); settle();
        chk({tag, "_redir_N3"}, {31'b0, redirect_o}, 32'd1);
        chk({tag, "_rpc_N3"}, redirect_pc_o, target);
        chk({tag, "_mret_N3"}, {31'b0, mret_o}, 32'd0);
        chk({tag, "_we_N3"}, {31'b0, we_exc_o}, 32'd0);
        tick(); settle();
        chk({tag, "_stall_N4"}, {31'b0, stall_o}, 32'd0);
        chk({tag, "_redir_N4"}, {31'b0, redirect_o}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        mtvec_i = 32'h200; mepc_i = '0;
        rst_i = 1;
        tick(); tick();
        settle();
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        rst_i = 0;
        tick(); settle();
        chk("idle_stall", {31'b0, stall_o}, 32'd0);

        // Illegal instruction, direct mode.
        valid_i = 1; pc_i = 32'h100; instruction_i = 32'hFFFF_FFFF; e_illegal_inst_i = 1;
        settle();
        trap_seq("ill", 32'h200);
        chk("ill_mcause", mcause_o, 32'd2);
        chk("ill_mtval", mtval_o, 32'hFFFF_FFFF);
        chk("ill_mepc", mepc_o, 32'h100);

        // MEI + MTI in vectored mode; interrupt beats the simultaneous illegal.
        mtvec_i = 32'h301;
        valid_i = 1; pc_i = 32'h40; instruction_i = 32'h1; e_illegal_inst_i = 1;
        xint_meip_i = 1; xint_mtip_i = 1; mie_i = 32'h0000_0880; mstatus_mie_i = 1;
        settle();
        trap_seq("mei", 32'h32C);
        chk("mei_mcause", mcause_o, 32'h8000_000B);
        chk("mei_mtval", mtval_o, 32'd0);
        chk("mei_mepc", mepc_o, 32'h40);

        // Same interrupts globally disabled, with ecall: base target.
        valid_i = 1; pc_i = 32'h44; is_ecall_i = 1;
        xint_meip_i = 1; xint_mtip_i = 1; mie_i = 32'h0000_0880; mstatus_mie_i = 0;
        settle();
        trap_seq("ecall", 32'h300);
        chk("ecall_mcause", mcause_o, 32'd11);
        chk("ecall_mtval", mtval_o, 32'd0);

        // MSI over MTI, vectored: 0x300 + 4*3.
        valid_i = 1; pc_i = 32'h48; xint_msip_i = 1; xint_mtip_i = 1;
        mie_i = 32'h0000_0088; mstatus_mie_i = 1;
        settle();
        trap_seq("msi", 32'h30C);
        chk("msi_mcause", mcause_o, 32'h8000_0003);

        // MRET.
        mepc_i = 32'h1234;
        valid_i = 1; is_mret_i = 1; pc_i = 32'h60;
        settle();
        chk("mret_kill_N", {31'b0, kill_wb_o}, 32'd1);
        tick(); clear_inputs(); settle();
        chk("mret_flush_N1", {31'b0, flush_o}, 32'd1);
        chk("mret_we_N1", {31'b0, we_exc_o}, 32'd0);
        tick(); settle();
        chk("mret_redir_N2", {31'b0, redirect_o}, 32'd1);
        chk("mret_strobe_N2", {31'b0, mret_o}, 32'd1);
        chk("mret_rpc_N2", redirect_pc_o, 32'h1234);
        chk("mret_we_N2", {31'b0, we_exc_o}, 32'd0);
        tick(); settle();
        chk("mret_stall_N3", {31'b0, stall_o}, 32'd0);
        chk("mret_hold_mcause", mcause_o, 32'h8000_0003);
        chk("mret_hold_mepc", mepc_o, 32'h48);

        // Trap wins over MRET in the same cycle.
        mtvec_i = 32'h200;
        valid_i = 1; is_mret_i = 1; is_ebreak_i = 1; pc_i = 32'h70;
        settle();
        trap_seq("ebrk", 32'h200);
        chk("ebrk_mcause", mcause_o, 32'd3);
        chk("ebrk_mtval", mtval_o, 32'h70);

        // Store misaligned alone; then instruction-address misaligned.
        valid_i = 1; pc_i = 32'h74; mem_addr_i = 32'h2002; e_st_addr_mis_i = 1;
        settle();
        trap_seq("stmis", 32'h200);
        chk("stmis_mcause", mcause_o, 32'd6);
        chk("stmis_mtval", mtval_o, 32'h2002);
        valid_i = 1; pc_i = 32'h7A; e_inst_addr_mis_i = 1; e_illegal_inst_i = 1;
        settle();
        trap_seq("iamis", 32'h200);
        chk("iamis_mcause", mcause_o, 32'd0);
        chk("iamis_mtval", mtval_o, 32'h7A);

        // Load misaligned + illegal, then reset during WRITE.
        valid_i = 1; pc_i = 32'h80; instruction_i = 32'h1234_5678;
        mem_addr_i = 32'h1003; e_ld_addr_mis_i = 1; e_illegal_inst_i = 1;
        settle();
        chk("ldill_kill", {31'b0, kill_wb_o}, 32'd1);
        tick(); clear_inputs(); settle();
        chk("ldill_mcause", mcause_o, 32'd2);
        chk("ldill_mtval", mtval_o, 32'h1234_5678);
        tick(); settle();
        chk("ldill_we", {31'b0, we_exc_o}, 32'd1);
        rst_i = 1;
        settle();
        chk("rstw_we", {31'b0, we_exc_o}, 32'd0);
        chk("rstw_stall", {31'b0, stall_o}, 32'd0);
        tick(); rst_i = 0; settle();
        chk("rstw_stall_after", {31'b0, stall_o}, 32'd0);
        chk("rstw_redir_after", {31'b0, redirect_o}, 32'd0);
        chk("rstw_flush_after", {31'b0, flush_o}, 32'd0);
        chk("rstw_mcause", mcause_o, 32'd0);
        chk("rstw_mepc", mepc_o, 32'd0);
        chk("rstw_mtval", mtval_o, 32'd0);
        tick(); settle();
        chk("rstw_no_resume", {31'b0, redirect_o}, 32'd0);

        // valid_i=0 ignores trap inputs.
        pc_i = 32'h90; e_illegal_inst_i = 1; is_ecall_i = 1; xint_meip_i = 1;
        mie_i = 32'hFFFF_FFFF; mstatus_mie_i = 1;
        settle();
        chk("nv_kill", {31'b0, kill_wb_o}, 32'd0);
        tick(); settle();
        chk("nv_stall", {31'b0, stall_o}, 32'd0);
        chk("nv_mcause", mcause_o, 32'd0);
        clear_inputs();

        // Events during FLUSH are dropped; latched values hold.
        valid_i = 1; pc_i = 32'h500; is_ebreak_i = 1;
        settle();
        tick(); clear_inputs();
        valid_i = 1; pc_i = 32'h600; is_ecall_i = 1; e_illegal_inst_i = 1; is_mret_i = 1;
        settle();
        chk("fl_flush", {31'b0, flush_o}, 32'd1);
        chk("fl_kill", {31'b0, kill_wb_o}, 32'd0);
        tick(); settle();
        chk("fl_mcause", mcause_o, 32'd3);
        chk("fl_mepc", mepc_o, 32'h500);
        chk("fl_mtval", mtval_o, 32'h500);
        tick(); settle();
        chk("fl_redir", {31'b0, redirect_o}, 32'd1);
        chk("fl_rpc", redirect_pc_o, 32'h200);
        tick(); clear_inputs(); settle();
        chk("fl_idle", {31'b0, stall_o}, 32'd0);
        tick(); settle();
        chk("fl_no_queue", {31'b0, flush_o}, 32'd0);
        chk("fl_hold_mepc", mepc_o, 32'h500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
